// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - host request/response, clear control and RAM array bus bundle
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_write;
  logic [DATA_W-1:0] resp_rdata;
  logic              clr_start;
  logic              clr_busy;
  logic              mem_cs_n;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_adrs;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  // master: host plus RAM array side; slave: the access controller
  modport master (
    output req_valid, req_write, req_addr, req_wdata, clr_start, mem_data_out,
    input  req_ready, resp_valid, resp_write, resp_rdata, clr_busy,
    input  mem_cs_n, mem_rw, mem_adrs, mem_data_in
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, clr_start, mem_data_out,
    output req_ready, resp_valid, resp_write, resp_rdata, clr_busy,
    output mem_cs_n, mem_rw, mem_adrs, mem_data_in
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - RAM array initiator: setup/access/hold sequencing and self-timed zero-fill
module ram_access_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_access_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0]  ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ACC_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   CLR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  acc_cnt;
  logic [ADDR_W:0]   clr_cnt;
  logic [ADDR_W:0]   clr_cnt_inc;
  logic              clr_mode;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept_clr;
  logic              accept_req;
  logic              acc_done;
  logic              clr_done;

  assign clr_cnt_inc = clr_cnt + CLR_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    accept_clr     = 1'b0;
    accept_req     = 1'b0;
    acc_done       = 1'b0;
    clr_done       = 1'b0;
    bus.req_ready  = 1'b0;
    bus.mem_cs_n   = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_write = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = rst_n;
        // a pending clear always takes priority over a host request
        if (bus.clr_start) begin
          accept_clr = 1'b1;
          state_nxt  = SETUP;
        end else if (bus.req_valid) begin
          accept_req = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_cs_n = 1'b0;
        if (acc_cnt == '0) begin
          acc_done  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (clr_mode) begin
          if (clr_cnt == CLR_LAST) begin
            clr_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = SETUP;
          end
        end else begin
          bus.resp_valid = 1'b1;
          bus.resp_write = wr_q;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      clr_cnt  <= '0;
      clr_mode <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == SETUP) begin
        acc_cnt <= ACC_LAST;
      end else if (state == ACCESS && acc_cnt != '0) begin
        acc_cnt <= acc_cnt - ACC_ONE;
      end

      if (accept_clr) begin
        clr_mode <= 1'b1;
        clr_cnt  <= '0;
        wr_q     <= 1'b1;
        addr_q   <= '0;
        data_q   <= '0;
      end else if (accept_req) begin
        wr_q   <= bus.req_write;
        addr_q <= bus.req_addr;
        data_q <= bus.req_wdata;
      end

      // zero-fill traffic never disturbs the last host read result
      if (acc_done && !clr_mode) begin
        rdata_q <= wr_q ? '0 : bus.mem_data_out;
      end

      if (state == HOLD && clr_mode) begin
        if (clr_done) begin
          clr_mode <= 1'b0;
        end else begin
          clr_cnt <= clr_cnt_inc;
          addr_q  <= clr_cnt_inc[ADDR_W-1:0];
        end
      end
    end
  end

  assign bus.mem_rw      = wr_q;
  assign bus.mem_adrs    = addr_q;
  assign bus.mem_data_in = data_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.clr_busy    = clr_mode;
endmodule
